instr_assembler: RTL
====================

Name: instr_assembler

Overview:
Packs decoded MIPS instruction fields back into 32-bit machine words; the inverse of the field splitter.
Accepts one field tuple per valid/ready handshake and formats it as R, I or J type.
Tags each word with a sequential word address starting at the instruction-memory base.
Buffers words in a small FIFO for the IM loader or testbench writer to drain.

Parameters:
BASE_ADDR, 32'h0000_3000, address tagged on the first word after reset or clr
FIFO_DEPTH, 2, output FIFO entries; power of two, >= 2

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high reset
clr  input  1  synchronous flush: empties FIFO, restores address, returns FSM to IDLE
in_valid  input  1  field tuple valid
in_ready  output  1  tuple accepted when in_valid && in_ready
fmt  input  2  00 R, 01 I, 10 J, 11 LI pseudo (macro) / illegal
op  input  6  opcode [31:26]
rs  input  5  [25:21]
rt  input  5  [20:16]
rd  input  5  [15:11], R only
shamt  input  5  [10:6], R only
funct  input  6  [5:0], R only
imm16  input  16  [15:0], I only
idx26  input  26  [25:0], J only
li_imm  input  32  LI immediate; ignored unless macro is enabled
out_valid  output  1  FIFO non-empty
out_ready  input  1  pop when out_valid && out_ready
out_instr  output  32  head word
out_addr  output  32  head word address
word_cnt  output  16  words pushed since reset/clr, saturates at 16'hFFFF
err  output  1  one-cycle pulse on illegal accept

Behaviour:
- Reset (async) and clr (sync, highest priority over all other events):
  - FIFO empty; out_valid=0; out_instr=0; out_addr=0; storage zeroed.
  - addr_cnt=BASE_ADDR; word_cnt=0; err=0; state=IDLE.
- in_ready = (state==IDLE) && FIFO not full. No pass-through: in_ready is low when full, even if a pop occurs in the same cycle.
- Packing on accept:
  - R: {op,rs,rt,rd,shamt,funct}
  - I: {op,rs,rt,imm16}
  - J: {op,idx26}
- Each push:
  - Entry stores {instr, addr_cnt}.
  - addr_cnt += 4, wraps mod 2^32.
  - word_cnt += 1, saturating.
- Latency: a word accepted in cycle N is visible on out_* in cycle N+1 if the FIFO was empty.
- FIFO is strict FIFO order. Push and pop in the same cycle (not full) both occur; occupancy is unchanged.
- out_instr/out_addr are driven from head storage; they hold the last values when empty (0 after reset).
- fmt=11 without macro:
  - Tuple is accepted (consumed); err=1 for exactly one cycle.
  - No push; addr_cnt and word_cnt unchanged.
- FSM states: IDLE, LI_LO (LI_LO is reachable only with the macro).

Optional Feature:
- Macro: INSTR_ASSEMBLER_LI_EXPAND_EN.
- With macro, fmt=11 is the LI pseudo-op, expanded to two words:
  - Accept cycle: push lui = {6'h0F,5'd0,rt,li_imm[31:16]}. Latch rt and li_imm[15:0]; go to LI_LO.
  - LI_LO: in_ready=0. When FIFO is not full, push ori = {6'h0D,rt_l,rt_l,lo16_l} and return to IDLE; otherwise wait in LI_LO.
  - Each word gets its own address (+4 each); word_cnt += 2 in total.
  - clr or reset in LI_LO abandons the ori and returns to IDLE.
- Without macro: fmt=11 is illegal as described in Behaviour, and the LI_LO logic is not compiled.

Test Plan:
- R addu $3,$1,$2 (op0 rs1 rt2 rd3 shamt0 funct 0x21) after reset -> next cycle out_valid=1, out_instr=0x00221821, out_addr=0x3000, word_cnt=1.
- I ori $1,$0,0x1234 then J idx26=0xC00 -> out_instr 0x34011234 @0x3004, then 0x08000C00 @0x3008, in order.
- out_ready=0, offer 3 tuples -> in_ready drops after 2 pushes, third held stable. Raise out_ready -> all 3 drain in order with consecutive addresses.
- fmt=11, no macro -> err pulses 1 cycle, no output; next R word gets the address the illegal one would have had.
- Macro on, LI rt=5 li_imm=0x12345678 -> 0x3C051234 then 0x34A55678 at consecutive addresses; in_ready low during LI_LO; with FIFO full, LI_LO waits.
- Assert reset mid-LI_LO and clr with 2 words queued -> out_valid=0 immediately (reset) / next edge (clr); next word tagged 0x3000, word_cnt restarts at 1.

Source files
------------

// File: rtl/instr_assembler.sv
// instr_assembler: packs MIPS R/I/J field tuples into address-tagged words queued in an output FIFO.
// Optional macro INSTR_ASSEMBLER_LI_EXPAND_EN expands fmt=11 (LI) into a lui/ori pair.
module instr_assembler #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_3000,
  parameter int FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clr,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  fmt,
  input  logic [5:0]  op,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [4:0]  shamt,
  input  logic [5:0]  funct,
  input  logic [15:0] imm16,
  input  logic [25:0] idx26,
  input  logic [31:0] li_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_addr,
  output logic [15:0] word_cnt,
  output logic        err
);
  localparam int AW = $clog2(FIFO_DEPTH);
  typedef enum logic {IDLE, LI_LO} state_t;
  state_t state;
  logic [31:0] instr_mem [FIFO_DEPTH];
  logic [31:0] addr_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr, head_ptr;
  logic [AW:0] count;
  logic [31:0] addr_cnt, push_word, base_word;
  logic full, accept, push, pop, illegal;
`ifdef INSTR_ASSEMBLER_LI_EXPAND_EN
  logic [4:0] rt_l;
  logic [15:0] lo16_l;
`else
  logic unused_li;
  assign unused_li = ^li_imm;
`endif
  always_comb begin
    full = count == (AW+1)'(FIFO_DEPTH);
    in_ready = state == IDLE && !full;
    accept = in_valid && in_ready;
    out_valid = count != '0;
    pop = out_valid && out_ready;
    // When empty, the head pointer looks back at the last popped slot so outputs hold.
    head_ptr = out_valid ? rd_ptr : rd_ptr - AW'(1);
    out_instr = instr_mem[head_ptr];
    out_addr = addr_mem[head_ptr];
    base_word = fmt == 2'b10 ? {op, idx26} :
                fmt == 2'b01 ? {op, rs, rt, imm16} :
                {op, rs, rt, rd, shamt, funct};
`ifdef INSTR_ASSEMBLER_LI_EXPAND_EN
    illegal = 1'b0;
    push = accept || (state == LI_LO && !full);
    push_word = state == LI_LO ? {6'h0D, rt_l, rt_l, lo16_l} :
                fmt == 2'b11 ? {6'h0F, 5'd0, rt, li_imm[31:16]} : base_word;
`else
    illegal = accept && fmt == 2'b11;
    push = accept && fmt != 2'b11;
    push_word = base_word;
`endif
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        instr_mem[i] <= '0;
        addr_mem[i] <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      addr_cnt <= BASE_ADDR;
      word_cnt <= '0;
      err <= 1'b0;
      state <= IDLE;
    end else if (clr) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        instr_mem[i] <= '0;
        addr_mem[i] <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      addr_cnt <= BASE_ADDR;
      word_cnt <= '0;
      err <= 1'b0;
      state <= IDLE;
    end else begin
      if (push) begin
        instr_mem[wr_ptr] <= push_word;
        addr_mem[wr_ptr] <= addr_cnt;
        wr_ptr <= wr_ptr + AW'(1);
        addr_cnt <= addr_cnt + 32'd4;
        if (word_cnt != 16'hFFFF) word_cnt <= word_cnt + 16'd1;
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
      err <= illegal;
`ifdef INSTR_ASSEMBLER_LI_EXPAND_EN
      if (accept && fmt == 2'b11) begin
        state <= LI_LO;
        rt_l <= rt;
        lo16_l <= li_imm[15:0];
      end else if (state == LI_LO && !full) state <= IDLE;
`endif
    end
  end
endmodule
